// File: rtl/cir_peak_window_if.sv
// Stream handshake bundle ({I,Q} data, valid/ready, frame-end marker) for the CIR peak window stage.
interface cir_peak_window_if #(
    parameter int unsigned W = 32
);
    logic [W-1:0] TDATA;
    logic         TVALID;
    logic         TREADY;
    logic         TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/cir_peak_window.sv
// Buffers one tlast-delimited SC16 CIR frame, tracks the |I|+|Q| peak, then replays it as full frame,
// magnitude stream, window around the peak, or a single peak report word.
module cir_peak_window #(
    parameter int unsigned LOG_DEPTH = 10,
    parameter int unsigned IQ_W      = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    cir_peak_window_if.slave     i_data,
    cir_peak_window_if.master    o_data,
    input  logic [1:0]           MODE,
    input  logic [LOG_DEPTH-1:0] PRE,
    input  logic [LOG_DEPTH:0]   WIN_LEN,
    output logic                 overflow,
    output logic [15:0]          frame_cnt
);
    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam int unsigned DW    = 2 * IQ_W;
    localparam int unsigned CW    = LOG_DEPTH + 1;

    typedef enum logic {StFill, StDrain} state_e;
    state_e state_q, state_d;

    logic [DW-1:0]        mem [DEPTH];
    logic                 live_q;
    logic [CW-1:0]        count_q;
    logic [LOG_DEPTH-1:0] peak_idx_q, peak_idx_d;
    logic [IQ_W:0]        peak_mag_q, peak_mag_d;
    logic [1:0]           mode_q;
    logic [CW-1:0]        rd_addr_q, rd_end_q, rd_next;
    logic [DW-1:0]        ram_q;
    logic                 rd_valid_q, rd_last_q;
    logic [DW-1:0]        o_data_q;
    logic                 o_valid_q, o_last_q;
    logic                 overflow_q;
    logic [15:0]          frame_cnt_q;

    function automatic logic [IQ_W-1:0] sat_abs(input logic [IQ_W-1:0] v);
        if (v == {1'b1, {(IQ_W-1){1'b0}}}) return {1'b0, {(IQ_W-1){1'b1}}};
        else if (v[IQ_W-1]) return -v;
        else return v;
    endfunction

    function automatic logic [IQ_W:0] cplx_mag(input logic [DW-1:0] w);
        return {1'b0, sat_abs(w[DW-1:IQ_W])} + {1'b0, sat_abs(w[IQ_W-1:0])};
    endfunction

    logic                 in_fire, in_last, store, peak_load;
    logic [IQ_W:0]        in_mag, ram_mag;
    logic [CW-1:0]        len_c, win_len, win_end, start_c, end_c;
    logic [LOG_DEPTH-1:0] win_start;
    logic [CW:0]          win_sum;
    logic                 out_fire, out_adv, s1_adv, issue, ren;
    logic [IQ_W-1:0]      peak_sat;
    logic [DW-1:0]        fmt_word;

    // Capture side: peak tracking and drain range, resolved in the cycle TLAST is accepted.
    always_comb begin
        in_fire    = i_data.TVALID & i_data.TREADY;
        in_last    = in_fire & i_data.TLAST;
        store      = in_fire && (count_q < CW'(DEPTH));
        in_mag     = cplx_mag(i_data.TDATA);
        peak_load  = store && ((count_q == '0) || (in_mag > peak_mag_q));
        peak_idx_d = peak_load ? count_q[LOG_DEPTH-1:0] : peak_idx_q;
        peak_mag_d = peak_load ? in_mag : peak_mag_q;
        len_c      = store ? count_q + CW'(1) : count_q;
        win_start  = (peak_idx_d >= PRE) ? peak_idx_d - PRE : '0;
        win_len    = (WIN_LEN == '0) ? CW'(1) : WIN_LEN;
        win_sum    = {2'b00, win_start} + {1'b0, win_len};
        win_end    = (win_sum > {1'b0, len_c}) ? len_c : win_sum[CW-1:0];
        start_c    = '0;
        end_c      = len_c;
        case (MODE)
            2'd2: begin
                start_c = CW'(win_start);
                end_c   = win_end;
            end
            2'd3: end_c = CW'(1);
            default: ;
        endcase
    end

    // Drain side: read issue -> RAM data register -> output register, each stage stalls independently.
    always_comb begin
        out_fire = o_valid_q & o_data.TREADY;
        out_adv  = ~o_valid_q | o_data.TREADY;
        s1_adv   = ~rd_valid_q | out_adv;
        issue    = (state_q == StDrain) && (rd_addr_q < rd_end_q) && s1_adv;
        ren      = issue && (mode_q != 2'd3);
        rd_next  = rd_addr_q + CW'(1);
        ram_mag  = cplx_mag(ram_q);
        peak_sat = peak_mag_q[IQ_W] ? {IQ_W{1'b1}} : peak_mag_q[IQ_W-1:0];
        case (mode_q)
            2'd1:    fmt_word = DW'(ram_mag);
            2'd3:    fmt_word = {IQ_W'(peak_idx_q), peak_sat};
            default: fmt_word = ram_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= StFill;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFill:  if (in_last) state_d = StDrain;
            StDrain: if (out_fire && o_last_q) state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        i_data.TREADY = (state_q == StFill) && live_q;
        o_data.TDATA  = o_data_q;
        o_data.TVALID = o_valid_q;
        o_data.TLAST  = o_last_q;
        overflow      = overflow_q;
        frame_cnt     = frame_cnt_q;
    end

    always_ff @(posedge ap_clk) begin
        if (store) mem[count_q[LOG_DEPTH-1:0]] <= i_data.TDATA;
        if (ren)   ram_q <= mem[rd_addr_q[LOG_DEPTH-1:0]];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            live_q      <= 1'b0;
            count_q     <= '0;
            peak_idx_q  <= '0;
            peak_mag_q  <= '0;
            mode_q      <= '0;
            rd_addr_q   <= '0;
            rd_end_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (in_fire) begin
                if (store) count_q <= count_q + CW'(1);
                else       overflow_q <= 1'b1;
                peak_idx_q <= peak_idx_d;
                peak_mag_q <= peak_mag_d;
                if (i_data.TLAST) begin
                    count_q   <= '0;
                    mode_q    <= MODE;
                    rd_addr_q <= start_c;
                    rd_end_q  <= end_c;
                end
            end
            if (issue) rd_addr_q <= rd_next;
            if (s1_adv) begin
                rd_valid_q <= issue;
                if (issue) rd_last_q <= (rd_next == rd_end_q);
            end
            if (out_adv) begin
                o_valid_q <= rd_valid_q;
                o_last_q  <= rd_valid_q & rd_last_q;
                if (rd_valid_q) o_data_q <= fmt_word;
            end
            if (out_fire && o_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_cir_peak_window.sv
// Directed bench for cir_peak_window: a LOG_DEPTH=10 instance for mode/window checks and a
// LOG_DEPTH=3 instance for truncation and overflow behaviour.
module tb_cir_peak_window;
    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;
    logic ap_rst_n;

    cir_peak_window_if #(.W(32)) a_in ();
    cir_peak_window_if #(.W(32)) a_out ();
    cir_peak_window_if #(.W(32)) b_in ();
    cir_peak_window_if #(.W(32)) b_out ();

    logic [1:0]  a_mode, b_mode;
    logic [9:0]  a_pre;
    logic [10:0] a_win;
    logic [2:0]  b_pre;
    logic [3:0]  b_win;
    logic        a_ovf, b_ovf;
    logic [15:0] a_fc, b_fc;

    cir_peak_window #(.LOG_DEPTH(10), .IQ_W(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .i_data(a_in), .o_data(a_out),
        .MODE(a_mode), .PRE(a_pre), .WIN_LEN(a_win), .overflow(a_ovf), .frame_cnt(a_fc)
    );
    cir_peak_window #(.LOG_DEPTH(3), .IQ_W(16)) dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .i_data(b_in), .o_data(b_out),
        .MODE(b_mode), .PRE(b_pre), .WIN_LEN(b_win), .overflow(b_ovf), .frame_cnt(b_fc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    logic [31:0] smp   [64];
    logic [31:0] exp_w [64];
    logic [32:0] qa [$];
    logic [32:0] qb [$];
    int ready_mode = 1;  // 0 stalled, 1 always ready, 2 random

    always @(posedge ap_clk) begin
        #1;
        case (ready_mode)
            0:       a_out.TREADY = 1'b0;
            1:       a_out.TREADY = 1'b1;
            default: a_out.TREADY = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitors: record transfers and check words stay put while stalled.
    logic        a_stall = 1'b0;
    logic [32:0] a_held;
    always @(negedge ap_clk) begin
        if (!ap_rst_n) a_stall = 1'b0;
        else begin
            if (a_stall) begin
                check("hold_valid", a_out.TVALID, 1);
                check("hold_word", {a_out.TLAST, a_out.TDATA}, a_held);
            end
            if (a_out.TVALID && a_out.TREADY) qa.push_back({a_out.TLAST, a_out.TDATA});
            a_stall = a_out.TVALID && !a_out.TREADY;
            a_held  = {a_out.TLAST, a_out.TDATA};
        end
    end

    always @(negedge ap_clk) begin
        if (ap_rst_n && b_out.TVALID && b_out.TREADY) qb.push_back({b_out.TLAST, b_out.TDATA});
    end

    function automatic int mag(input logic [31:0] w);
        int i, q;
        i = $signed(w[31:16]);
        q = $signed(w[15:0]);
        if (i < 0) i = -i;
        if (q < 0) q = -q;
        if (i > 32767) i = 32767;
        if (q > 32767) q = 32767;
        return i + q;
    endfunction

    task automatic mk_ramp(input int n, input int p);
        for (int i = 0; i < n; i++) smp[i] = {16'(i), 16'd1};
        if (p >= 0 && p < n) smp[p] = 32'h0064_FF9C;  // {100,-100}
    endtask

    task automatic drive_a(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            a_in.TDATA  = smp[i];
            a_in.TVALID = 1'b1;
            a_in.TLAST  = (i == n - 1);
            @(negedge ap_clk);
            while (!a_in.TREADY && guard < 500) begin
                @(negedge ap_clk);
                guard++;
            end
            if (guard >= 500) fail("a_in_ready");
            @(posedge ap_clk);
            #1;
        end
        a_in.TVALID = 1'b0;
        a_in.TLAST  = 1'b0;
    endtask

    task automatic drive_b(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            b_in.TDATA  = smp[i];
            b_in.TVALID = 1'b1;
            b_in.TLAST  = (i == n - 1);
            @(negedge ap_clk);
            while (!b_in.TREADY && guard < 500) begin
                @(negedge ap_clk);
                guard++;
            end
            if (guard >= 500) fail("b_in_ready");
            @(posedge ap_clk);
            #1;
        end
        b_in.TVALID = 1'b0;
        b_in.TLAST  = 1'b0;
    endtask

    task automatic expect_a(input string name, input int n);
        int guard;
        guard = 0;
        while (qa.size() < n && guard < 2000) begin
            @(posedge ap_clk);
            guard++;
        end
        repeat (4) @(posedge ap_clk);
        #1;
        check({name, "_count"}, qa.size(), n);
        for (int i = 0; i < n && i < qa.size(); i++)
            check($sformatf("%s_w%0d", name, i), qa[i], {(i == n - 1), exp_w[i]});
        qa.delete();
    endtask

    task automatic expect_b(input string name, input int n);
        int guard;
        guard = 0;
        while (qb.size() < n && guard < 2000) begin
            @(posedge ap_clk);
            guard++;
        end
        repeat (4) @(posedge ap_clk);
        #1;
        check({name, "_count"}, qb.size(), n);
        for (int i = 0; i < n && i < qb.size(); i++)
            check($sformatf("%s_w%0d", name, i), qb[i], {(i == n - 1), exp_w[i]});
        qb.delete();
    endtask

    typedef struct {
        logic [1:0] mode;
        int         pre;
        int         win;
        int         peak;
        int         start;
        int         cnt;
    } vec_t;
    vec_t tbl [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 16-sample ramp {i,1} with {100,-100} injected at .peak; start/cnt hand-computed.
        tbl[0] = '{mode: 2'd2, pre: 5, win: 4,  peak: 2,  start: 0,  cnt: 4};
        tbl[1] = '{mode: 2'd2, pre: 1, win: 6,  peak: 14, start: 13, cnt: 3};
        tbl[2] = '{mode: 2'd2, pre: 0, win: 0,  peak: 7,  start: 7,  cnt: 1};
        tbl[3] = '{mode: 2'd2, pre: 3, win: 16, peak: 10, start: 7,  cnt: 9};
        tbl[4] = '{mode: 2'd0, pre: 0, win: 0,  peak: 5,  start: 0,  cnt: 16};
        tbl[5] = '{mode: 2'd1, pre: 0, win: 0,  peak: 4,  start: 0,  cnt: 16};
        tbl[6] = '{mode: 2'd3, pre: 0, win: 0,  peak: 11, start: 0,  cnt: 1};

        ap_rst_n = 1'b0;
        a_in.TDATA = '0; a_in.TVALID = 1'b0; a_in.TLAST = 1'b0;
        b_in.TDATA = '0; b_in.TVALID = 1'b0; b_in.TLAST = 1'b0;
        b_out.TREADY = 1'b1;
        a_mode = 2'd0; a_pre = '0; a_win = '0;
        b_mode = 2'd0; b_pre = '0; b_win = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_tvalid", a_out.TVALID, 0);
        check("rst_tlast", a_out.TLAST, 0);
        check("rst_tdata", a_out.TDATA, 0);
        check("rst_tready", a_in.TREADY, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_fc", a_fc, 0);
        check("rst_b_tready", b_in.TREADY, 0);
        ap_rst_n = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rel_tready", a_in.TREADY, 1);

        // Full frame with first-word latency.
        smp[0] = 32'h0001_0002; smp[1] = 32'h0003_FFFC; smp[2] = 32'h0000_0000; smp[3] = 32'h0005_0005;
        for (int i = 0; i < 4; i++) exp_w[i] = smp[i];
        a_mode = 2'd0;
        drive_a(4);
        check("busy_tready", a_in.TREADY, 0);
        @(posedge ap_clk);
        #1;
        check("lat1_valid", a_out.TVALID, 0);
        @(posedge ap_clk);
        #1;
        check("lat2_valid", a_out.TVALID, 1);
        check("lat2_data", a_out.TDATA, 32'h0001_0002);
        expect_a("m0", 4);

        // Magnitude saturation, then peak report on the same samples.
        smp[0] = 32'h8000_0000; smp[1] = 32'h0064_FF9C;
        exp_w[0] = 32'h0000_7FFF; exp_w[1] = 32'h0000_00C8;
        a_mode = 2'd1;
        drive_a(2);
        expect_a("m1", 2);
        exp_w[0] = 32'h0000_7FFF;
        a_mode = 2'd3;
        drive_a(2);
        expect_a("m3", 1);

        for (int t = 0; t < 7; t++) begin
            mk_ramp(16, tbl[t].peak);
            a_mode = tbl[t].mode;
            a_pre  = 10'(tbl[t].pre);
            a_win  = 11'(tbl[t].win);
            drive_a(16);
            for (int j = 0; j < tbl[t].cnt; j++) begin
                if (tbl[t].mode == 2'd1)      exp_w[j] = 32'(mag(smp[tbl[t].start + j]));
                else if (tbl[t].mode == 2'd3) exp_w[j] = {16'(tbl[t].peak), 16'(mag(smp[tbl[t].peak]))};
                else                          exp_w[j] = smp[tbl[t].start + j];
            end
            expect_a($sformatf("tbl%0d", t), tbl[t].cnt);
        end

        // Equal peaks: first occurrence wins; random back-pressure from here on.
        ready_mode = 2;
        for (int i = 0; i < 12; i++) smp[i] = 32'h0001_0000;
        smp[3] = 32'h0019_0019;
        smp[9] = 32'hFFCE_0000;
        exp_w[0] = 32'h0003_0032;
        a_mode = 2'd3;
        drive_a(12);
        expect_a("tie", 1);
        mk_ramp(16, 6);
        for (int i = 0; i < 16; i++) exp_w[i] = smp[i];
        a_mode = 2'd0;
        drive_a(16);
        expect_a("rnd", 16);
        check("a_frame_cnt", a_fc, 12);

        // Small instance: exact fit, truncation, dropped peak, mode change during drain.
        mk_ramp(8, -1);
        for (int i = 0; i < 8; i++) exp_w[i] = smp[i];
        b_mode = 2'd0;
        drive_b(8);
        expect_b("b_exact", 8);
        check("b_ovf_exact", b_ovf, 0);
        mk_ramp(10, -1);
        drive_b(10);
        expect_b("b_trunc", 8);
        check("b_ovf_set", b_ovf, 1);
        mk_ramp(10, 9);
        exp_w[0] = 32'h0007_0008;
        b_mode = 2'd3;
        drive_b(10);
        expect_b("b_drop_peak", 1);
        mk_ramp(3, -1);
        for (int i = 0; i < 3; i++) exp_w[i] = smp[i];
        b_mode = 2'd0;
        drive_b(3);
        b_mode = 2'd3;
        expect_b("b_mode_hold", 3);
        check("b_ovf_sticky", b_ovf, 1);
        check("b_frame_cnt", b_fc, 4);

        // Reset while an 8-sample frame is stuck in drain.
        ready_mode = 0;
        mk_ramp(8, -1);
        a_mode = 2'd0;
        drive_a(8);
        repeat (4) @(posedge ap_clk);
        #1;
        check("stuck_valid", a_out.TVALID, 1);
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_out.TVALID, 0);
        check("mid_rst_fc", a_fc, 0);
        check("mid_rst_tready", a_in.TREADY, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        check("post_rst_tready", a_in.TREADY, 1);
        check("post_rst_valid", a_out.TVALID, 0);
        check("post_rst_fc", a_fc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
